src_memory_unit: RTL and testbench
==================================

// Module: src_memory_unit
// PURPOSE
//   Word-addressed main memory for the simple single-bus CPU. Contains its own MA (memory-address)
//   and MD (memory-data) registers and connects to the shared 32-bit tri-state CPU bus.
//   The control unit sequences transfers with MAin, MDbus, MDout, read and write strobes.
// PARAMETERS
//   W      32   data/bus width in bits
//   DEPTH  256  number of W-bit words in the array
//   AW     $clog2(DEPTH)  derived address width; not overridable
// PORTS
//   clk    in     1   clock; all state updates on rising edge
//   rst    in     1   synchronous, active-high reset
//   bus    inout  W   shared CPU bus (tri-state)
//   MAin   in     1   load MA from bus
//   MDbus  in     1   load MD from bus
//   MDout  in     1   drive MD onto bus
//   read   in     1   MD <= mem[MA]
//   write  in     1   mem[MA] <= MD
//   Wait   in     1   memory hold: suppresses read/write while high
// BEHAVIOUR
//   - Reset: rst=1 at a rising edge sets MA=0 and MD=0. bus is high-Z while MDout=0, independent of rst.
//     Array contents are not reset (see CONFIGURATION). rst overrides all strobes in that cycle.
//   - bus = MDout ? MD : 'z. This is combinational from the MD register.
//     Bus contention when MDout=1 and another driver is active is the control unit's responsibility.
//   - MAin=1 at an edge: MA <= bus. This is independent of read/write.
//   - Address: word index = MA[AW-1:0]. Upper MA bits are ignored, so addresses wrap modulo DEPTH.
//   - write=1 and Wait=0 at an edge: mem[MA_old] <= MD_old, using the register values before this edge.
//     write is level-sensitive: every edge it is held high repeats the write with the current MA/MD.
//   - read=1, write=0 and Wait=0 at an edge: MD <= mem[MA_old]. Read latency is 1 edge.
//     MD is valid on the bus from the cycle after the read edge, provided MDout=1.
//   - MD load priority, highest first: rst, read (when not waited), MDbus (MD <= bus).
//     If read and MDbus are both high, read wins.
//   - read and write both high with Wait=0: the write is performed and the read is ignored. MD then loads from bus if MDbus=1.
//   - Wait=1: read and write have no effect. MAin, MDbus and MDout still operate normally.
//     The control unit keeps read/write asserted until Wait drops.
//   - No internal state machine. Every transfer is a single edge.
// CONFIGURATION
//   MEM_CLEAR_ON_RST_EN: when defined, rst=1 also zeroes all DEPTH words over the same single edge,
//   so any read after reset returns 0.
//   When undefined: array contents survive reset and are X until first written.
//   The array then maps cleanly to block RAM.
// STRUCTURE
//   - Package mem_pkg:
//     - constants MEM_W=32 and MEM_DEPTH=256;
//     - typedef word_t = logic [MEM_W-1:0];
//     - typedef addr_t = logic [$clog2(MEM_DEPTH)-1:0].
//   - Sub-module mem_array: synchronous-write / synchronous-read W x DEPTH RAM with ports clk, we, addr, wdata, re, rdata.
//   - src_memory_unit contains: the MA/MD registers, the strobe priority logic, Wait gating, and the tri-state bus driver.
// TESTING
//   - Reset: rst=1 for 1 edge with MDout=1 -> bus reads 0. With MDout=0, bus is Z.
//   - Write/read-back:
//     - load MA=1 from bus, then MD=8, then write, giving mem[1]=8;
//     - same sequence for MA=2/MD=9;
//     - MAin with bus=1, read, then MDout -> bus=8;
//     - MAin with bus=2, read, then MDout -> bus=9.
//   - Held write: write high across the MA change from 1 to 2 while MD=8, then MD=9.
//     -> mem[1]=8, mem[2]=9 afterwards.
//   - Wait gating: mem[3]=5, Wait=1, MA=3, MD=7, write pulse -> read with Wait=0 returns 5.
//     Read issued with Wait=1 -> MD unchanged.
//   - Priority and wrap:
//     - read and MDbus together with bus=0xAA -> MD = mem[MA];
//     - MA=DEPTH+1 addresses word 1 (returns 8).
//   - MEM_CLEAR_ON_RST_EN defined: write mem[1]=8, then rst, then read addr 1 -> bus=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and types for the single-bus CPU main memory.
package mem_pkg;

    localparam int MEM_W     = 32;
    localparam int MEM_DEPTH = 256;

    typedef logic [MEM_W-1:0]             word_t;
    typedef logic [$clog2(MEM_DEPTH)-1:0] addr_t;

endpackage : mem_pkg

// File: rtl/mem_array.sv
// Synchronous-write / synchronous-read W x DEPTH word array.
// Optional feature macro: MEM_CLEAR_ON_RST_EN (adds a clr input that zeroes
// every word in one edge; without it the array has no reset and maps to block RAM).
module mem_array
    import mem_pkg::*;
#(
    parameter int W     = MEM_W,
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic                     clk,
`ifdef MEM_CLEAR_ON_RST_EN
    input  logic                     clr,
`endif
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

`ifdef MEM_CLEAR_ON_RST_EN
    // Clear has priority over a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[addr] <= wdata;
        end
    end
`else
    // Plain write port, no reset so the array stays RAM-inferable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end
`endif

    // Registered read; rdata holds its value until the next enabled read.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule : mem_array

// File: rtl/src_memory_unit.sv
// Main memory for the single-bus CPU: MA/MD registers, strobe priority,
// Wait gating and the tri-state bus driver around a mem_array.
// Optional feature macro: MEM_CLEAR_ON_RST_EN (rst also zeroes the array).
//
// Strobe semantics: every strobe is level-sampled at each rising edge and acts
// for that single edge. rst beats everything; Wait=1 suppresses read/write
// only; write beats read; read beats MDbus for the MD load.
module src_memory_unit
    import mem_pkg::*;
#(
    parameter int W     = MEM_W,
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    inout  wire  [W-1:0] bus,
    input  logic         MAin,
    input  logic         MDbus,
    input  logic         MDout,
    input  logic         read,
    input  logic         write,
    input  logic         Wait
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] ma_q, ma_d;
    logic [W-1:0] md_q, md_d;
    // MD is either the bus-loaded register or the RAM read register; this
    // select avoids copying RAM data into a second register and keeps the
    // read latency at exactly one edge.
    logic         md_sel_q, md_sel_d;

    logic [W-1:0] md_val;
    logic [W-1:0] rdata;
    logic         mem_we;
    logic         mem_re;
    logic [AW-1:0] mem_addr;
    logic          unused_ma_hi;

    assign md_val   = md_sel_q ? rdata : md_q;
    assign mem_addr = ma_q[AW-1:0];
    assign unused_ma_hi = ^ma_q[W-1:AW];

    // Memory strobes after reset override, Wait gating and write-over-read.
    always_comb begin
        mem_we = 1'b0;
        mem_re = 1'b0;
        if (!rst && !Wait) begin
            mem_we = write;
            mem_re = read && !write;
        end
    end

    // Next-state for MA and MD, priority rst > read > MDbus.
    always_comb begin
        ma_d     = ma_q;
        md_d     = md_q;
        md_sel_d = md_sel_q;
        if (rst) begin
            ma_d     = '0;
            md_d     = '0;
            md_sel_d = 1'b0;
        end else begin
            if (MAin) begin
                ma_d = bus;
            end
            if (mem_re) begin
                md_sel_d = 1'b1;
            end else if (MDbus) begin
                md_d     = bus;
                md_sel_d = 1'b0;
            end
        end
    end

    // MA/MD state registers.
    always_ff @(posedge clk) begin
        ma_q     <= ma_d;
        md_q     <= md_d;
        md_sel_q <= md_sel_d;
    end

    mem_array #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk   (clk),
`ifdef MEM_CLEAR_ON_RST_EN
        .clr   (rst),
`endif
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (md_val),
        .re    (mem_re),
        .rdata (rdata)
    );

    // Tri-state driver straight from the MD register.
    assign bus = MDout ? md_val : {W{1'bz}};

endmodule : src_memory_unit

// File: tb/tb_src_memory_unit.sv
// Directed self-checking bench for src_memory_unit.
// Honours MEM_CLEAR_ON_RST_EN when choosing post-reset array expectations.
module tb_src_memory_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         MAin;
    logic         MDbus;
    logic         MDout;
    logic         read;
    logic         write;
    logic         Wait;
    logic         tb_oe;
    logic [W-1:0] tb_val;
    wire  [W-1:0] bus;

    int n_checks;
    int n_errors;

    assign bus = tb_oe ? tb_val : {W{1'bz}};

    src_memory_unit dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .MAin  (MAin),
        .MDbus (MDbus),
        .MDout (MDout),
        .read  (read),
        .write (write),
        .Wait  (Wait)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ma(input logic [W-1:0] v);
        tb_oe = 1'b1; tb_val = v; MAin = 1'b1;
        step();
        MAin = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic load_md(input logic [W-1:0] v);
        tb_oe = 1'b1; tb_val = v; MDbus = 1'b1;
        step();
        MDbus = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic do_write();
        write = 1'b1;
        step();
        write = 1'b0;
    endtask

    task automatic do_read();
        read = 1'b1;
        step();
        read = 1'b0;
    endtask

    // Let MD onto the bus and sample it.
    task automatic sample_md(output logic [W-1:0] v);
        MDout = 1'b1;
        #1;
        v = bus;
        MDout = 1'b0;
        #1;
    endtask

    task automatic store(input logic [W-1:0] a, input logic [W-1:0] d);
        load_ma(a);
        load_md(d);
        do_write();
    endtask

    task automatic fetch(input logic [W-1:0] a, output logic [W-1:0] v);
        load_ma(a);
        do_read();
        sample_md(v);
    endtask

    logic [W-1:0] v;
    logic [W-1:0] exp_clr;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; MAin = 1'b0; MDbus = 1'b0; MDout = 1'b1;
        read = 1'b0; write = 1'b0; Wait = 1'b0;
        tb_oe = 1'b0; tb_val = '0;

        // Reset: MD cleared and visible on the bus.
        step();
        check("reset_md_on_bus", bus, 32'h0);
        rst = 1'b0;
        MDout = 1'b0;
        tb_oe = 1'b1; tb_val = 32'h5A5A_5A5A;
        #1;
        check("reset_bus_released", bus, 32'h5A5A_5A5A);
        tb_oe = 1'b0;

        // MD load from bus, and release of the bus with non-zero MD.
        load_md(32'h1234_5678);
        sample_md(v);
        check("mdbus_load", v, 32'h1234_5678);
        tb_oe = 1'b1; tb_val = 32'h0000_00A5;
        #1;
        check("bus_hiz_md_nonzero", bus, 32'h0000_00A5);
        tb_oe = 1'b0;

        // Write / read-back.
        store(32'd1, 32'd8);
        store(32'd2, 32'd9);
        store(32'd0, 32'h33);
        fetch(32'd1, v);
        check("readback_addr1", v, 32'd8);
        fetch(32'd2, v);
        check("readback_addr2", v, 32'd9);
        fetch(32'd0, v);
        check("readback_addr0", v, 32'h33);

        // Held write across an MA change and an MD change.
        store(32'd1, 32'h11);
        store(32'd2, 32'h22);
        load_ma(32'd1);
        load_md(32'd8);
        write = 1'b1;
        tb_oe = 1'b1; tb_val = 32'd2; MAin = 1'b1;   // mem[1]<=8, MA<=2
        step();
        MAin = 1'b0; tb_val = 32'd9; MDbus = 1'b1;   // mem[2]<=8, MD<=9
        step();
        MDbus = 1'b0; tb_oe = 1'b0;                  // mem[2]<=9
        step();
        write = 1'b0;
        fetch(32'd1, v);
        check("held_write_addr1", v, 32'd8);
        fetch(32'd2, v);
        check("held_write_addr2", v, 32'd9);

        // Wait gating of write and read; MAin/MDbus still work under Wait.
        store(32'd3, 32'd5);
        Wait = 1'b1;
        load_ma(32'd3);
        load_md(32'd7);
        do_write();
        Wait = 1'b0;
        do_read();
        sample_md(v);
        check("wait_blocks_write", v, 32'd5);
        load_md(32'h77);
        Wait = 1'b1;
        do_read();
        sample_md(v);
        check("wait_blocks_read", v, 32'h77);
        load_ma(32'd1);
        Wait = 1'b0;
        do_read();
        sample_md(v);
        check("main_under_wait", v, 32'd8);

        // read beats MDbus.
        load_ma(32'd1);
        read = 1'b1; MDbus = 1'b1; tb_oe = 1'b1; tb_val = 32'hAA;
        step();
        read = 1'b0; MDbus = 1'b0; tb_oe = 1'b0;
        sample_md(v);
        check("read_over_mdbus", v, 32'd8);

        // write beats read; MD still loads from bus.
        load_ma(32'd4);
        load_md(32'h44);
        write = 1'b1; read = 1'b1; MDbus = 1'b1; tb_oe = 1'b1; tb_val = 32'h55;
        step();
        write = 1'b0; read = 1'b0; MDbus = 1'b0; tb_oe = 1'b0;
        sample_md(v);
        check("write_over_read_md", v, 32'h55);
        fetch(32'd4, v);
        check("write_over_read_mem", v, 32'h44);

        // Address wrap modulo DEPTH.
        fetch(32'd257, v);
        check("wrap_read", v, 32'd8);
        store(32'd261, 32'h66);
        fetch(32'd5, v);
        check("wrap_write", v, 32'h66);

        // rst overrides strobes; array survives unless clear-on-reset is built in.
        load_ma(32'd1);
        load_md(32'h99);
        rst = 1'b1; write = 1'b1; read = 1'b1;
        step();
        rst = 1'b0; write = 1'b0; read = 1'b0;
        sample_md(v);
        check("rst_clears_md", v, 32'h0);
`ifdef MEM_CLEAR_ON_RST_EN
        exp_clr = 32'h0;
`else
        exp_clr = 32'h33;
`endif
        do_read();   // MA is 0 after reset
        sample_md(v);
        check("rst_clears_ma", v, exp_clr);
`ifdef MEM_CLEAR_ON_RST_EN
        exp_clr = 32'h0;
`else
        exp_clr = 32'd8;
`endif
        fetch(32'd1, v);
        check("array_after_rst", v, exp_clr);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Safety timeout.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule : tb_src_memory_unit
